// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_fsm
//  Description : Main control FSM of a multicycle MIPS-style datapath.
//                Sequences fetch/decode/execute/memory/write-back per opcode,
//                stalls on mem_ready and pulses instr_done on retirement.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control_fsm #(
    parameter int STALL_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BEQ       = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    state_t     r_state;
    state_t     w_next;
    logic       w_ready;

    // Strobes before reset masking
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_instr_done;
    logic       w_illegal_op;

    // With stalling disabled, memory is treated as always ready
    assign w_ready = (STALL_EN != 0) ? mem_ready : 1'b1;

    // State register; reset returns to FETCH from anywhere, even mid-stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore/ready-qualified output decode
    always_comb begin
        w_next          = S_FETCH;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_mem_write     = 1'b0;
        w_instr_done    = 1'b0;
        w_illegal_op    = 1'b0;
        iord            = 1'b0;
        mem_read        = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_op          = 2'b00;
        pc_source       = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                w_ir_write = w_ready;
                w_pc_write = w_ready;
                w_next     = w_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    c_OP_RTYPE:      w_next = S_R_EXEC;
                    c_OP_LW, c_OP_SW: w_next = S_MEM_ADR;
                    c_OP_BEQ:        w_next = S_BEQ;
                    c_OP_J:          w_next = S_JUMP;
                    c_OP_ADDI:       w_next = S_ADDI_EXEC;
                    default: begin
                        w_next       = S_FETCH;
                        w_illegal_op = 1'b1;
                        w_instr_done = 1'b1;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (opcode == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                w_next   = w_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                mem_to_reg   = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_write  = 1'b1;
                iord         = 1'b1;
                w_instr_done = w_ready;
                w_next       = w_ready ? S_FETCH : S_MEM_WR;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                w_reg_write  = 1'b1;
                reg_dst      = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a       = 1'b1;
                alu_op          = 2'b01;
                w_pc_write_cond = 1'b1;
                pc_source       = 2'b01;
                w_instr_done    = 1'b1;
                w_next          = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write   = 1'b1;
                pc_source    = 2'b10;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // State-changing strobes are suppressed while reset is held
    assign pc_write      = w_pc_write      & ~reset;
    assign pc_write_cond = w_pc_write_cond & ~reset;
    assign ir_write      = w_ir_write      & ~reset;
    assign reg_write     = w_reg_write     & ~reset;
    assign mem_write     = w_mem_write     & ~reset;
    assign instr_done    = w_instr_done    & ~reset;
    assign illegal_op    = w_illegal_op    & ~reset;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 The block SHALL have parameter STALL_EN, default 1: 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
REQ-002 The block SHALL have these ports, one clock domain, reset synchronous and active-high:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  6  instruction[31:26] from the IR; stable after FETCH completes
- mem_ready  in  1  memory access completes this cycle
- pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write  out  1 each  datapath strobes/selects
- reg_dst, mem_to_reg, reg_write, alu_src_a  out  1 each  register-file/ALU selects
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current state code
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode

Function
REQ-003 The block SHALL use these state codes: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BEQ=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-004 Outputs SHALL be Moore functions of state, except the mem_ready-qualified strobes and illegal_op/instr_done as specified; every signal not listed for a state SHALL be 0.
REQ-005 FETCH: mem_read=1, alu_src_b=01, ir_write=pc_write=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-006 DECODE: alu_src_b=11; next state by opcode:
- 000000 -> R_EXEC
- 100011 or 101011 -> MEM_ADR
- 000100 -> BEQ
- 000010 -> JUMP
- 001000 -> ADDI_EXEC
- any other -> FETCH, with illegal_op=1 and instr_done=1
REQ-007 MEM_ADR: alu_src_a=1, alu_src_b=10; go to MEM_RD if opcode=100011, else MEM_WR.
REQ-008 MEM_RD: mem_read=1, iord=1; stay until mem_ready, then go to MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; go to FETCH.
REQ-009 MEM_WR: mem_write=1, iord=1; stay until mem_ready, then go to FETCH with instr_done=1 in the mem_ready cycle.
REQ-010 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; go to R_WB. R_WB: reg_write=1, reg_dst=1; go to FETCH.
REQ-011 BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; go to FETCH.
REQ-012 JUMP: pc_write=1, pc_source=10; go to FETCH.
REQ-013 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; go to ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; go to FETCH.
REQ-014 instr_done SHALL be 1 in MEM_WB, R_WB, BEQ, JUMP and ADDI_WB, and in the cases given in REQ-006 and REQ-009.
REQ-015 With mem_ready=1 throughout, cycle counts SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2; each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR SHALL add exactly one cycle.
REQ-016 opcode SHALL be sampled only in DECODE and MEM_ADR; opcode changes in other states SHALL have no effect.

Reset
REQ-017 On a clk edge with reset=1, state SHALL become FETCH, including mid-instruction and mid-stall.
REQ-018 While reset=1, pc_write, pc_write_cond, ir_write, reg_write, mem_write, instr_done and illegal_op SHALL be forced to 0 combinationally.
REQ-019 The first cycle after reset deasserts SHALL be FETCH with mem_read=1.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- reset, then lw (100011) with mem_ready=1 -> states 0,1,2,3,4,0; instr_done only in state 4; reg_write=1 and mem_to_reg=1 in state 4.
- sw (101011), mem_ready low 2 cycles in MEM_WR -> state 5 held 3 cycles, mem_write=1 and iord=1 throughout; instr_done once, in the last cycle.
- FETCH with mem_ready=0 for 3 cycles -> state 0 held; ir_write=pc_write=0 until the mem_ready=1 cycle, then 1 for exactly one cycle.
- opcode 111111 -> states 0,1,0; illegal_op=instr_done=1 in state 1 only; no reg_write/mem_write/pc_write_cond asserted.
- beq then j -> beq: pc_write_cond=1, pc_source=01, alu_op=01 in state 8; j: pc_write=1, pc_source=10 in state 9; 3 cycles each.
- reset asserted during MEM_WR -> mem_write drops to 0 in the same cycle; state=0 after the edge; next instruction fetch proceeds normally.
